// File: rtl/rvv_uop_splitter.sv
// Splits an RVV vector instruction into per-register micro-ops according to LMUL.
// Widening split support is enabled by defining RVV_UOP_WIDEN_SPLIT_EN (otherwise widening is rejected).
module rvv_uop_splitter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst_encoding,
  input  logic [2:0]  inst_vsew,
  input  logic [2:0]  inst_vlmul,
  input  logic [7:0]  inst_vl,
  output logic        uop_valid,
  input  logic        uop_ready,
  output logic [31:0] uop_encoding,
  output logic [2:0]  uop_index,
  output logic        uop_last,
  output logic        illegal_pulse
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready;
  // the producer holds payload stable while valid && !ready.

  typedef enum logic {IDLE, SPLIT} state_t;

  localparam logic [6:0] OP_V     = 7'b1010111;
  localparam logic [2:0] OPIVV    = 3'b000;
  localparam logic [2:0] OPMVV    = 3'b010;
  localparam logic [2:0] OPMVX    = 3'b110;
  localparam logic [2:0] OPCFG    = 3'b111;
  localparam logic [2:0] SEW_LAST = 3'b100;

`ifdef RVV_UOP_WIDEN_SPLIT_EN
  localparam logic WIDEN_EN = 1'b1;
`else
  localparam logic WIDEN_EN = 1'b0;
`endif

  state_t      state, state_next;
  logic [31:0] enc_q;
  logic [2:0]  idx_q, last_q;
  logic        widen_q, vd_inc_q, vs1_inc_q;

  logic        accept;
  logic [5:0]  f6;
  logic [2:0]  f3;
  logic [4:0]  vd, vs1, vs2;
  logic [4:0]  lmul_cnt, uop_cnt, last_cnt, src_last, vd_align;
  logic [5:0]  vd_max, vs2_max, vs1_max;
  logic        is_widen, is_red, vd_inc, vs1_inc, misaligned, overflow, illegal;

  assign f6  = inst_encoding[31:26];
  assign vs2 = inst_encoding[24:20];
  assign vs1 = inst_encoding[19:15];
  assign f3  = inst_encoding[14:12];
  assign vd  = inst_encoding[11:7];

  assign inst_ready = (state == IDLE);
  assign accept     = inst_valid && inst_ready;

  // Classification of the instruction presented at the input.
  always_comb begin
    lmul_cnt   = 5'd1;
    case (inst_vlmul)
      3'b001:  lmul_cnt = 5'd2;
      3'b010:  lmul_cnt = 5'd4;
      3'b011:  lmul_cnt = 5'd8;
      default: lmul_cnt = 5'd1;
    endcase
    is_widen   = (inst_encoding[6:0] == OP_V) && ((f3 == OPMVV) || (f3 == OPMVX)) && (f6[5:4] == 2'b11);
    is_red     = ((f3 == OPMVV) && (f6[5:3] == 3'b000)) || ((f3 == OPIVV) && (f6[5:1] == 5'b11000));
    uop_cnt    = is_widen ? (inst_vlmul[2] ? 5'd1 : (lmul_cnt << 1)) : lmul_cnt;
    last_cnt   = uop_cnt - 5'd1;
    src_last   = is_widen ? (last_cnt >> 1) : last_cnt;
    vd_inc     = !is_red;
    vs1_inc    = ((f3 == OPIVV) || (f3 == OPMVV)) && !is_red;
    vd_align   = is_widen ? uop_cnt : lmul_cnt;
    misaligned = (vd_inc && ((vd & (vd_align - 5'd1)) != 5'd0)) ||
                 ((vs2 & (lmul_cnt - 5'd1)) != 5'd0);
    vd_max     = {1'b0, vd}  + (vd_inc  ? {1'b0, last_cnt} : 6'd0);
    vs2_max    = {1'b0, vs2} + {1'b0, src_last};
    vs1_max    = {1'b0, vs1} + (vs1_inc ? {1'b0, src_last} : 6'd0);
    overflow   = vd_max[5] || vs2_max[5] || vs1_max[5];
    illegal    = (inst_encoding[6:0] != OP_V) || (f3 == OPCFG) ||
                 (inst_vsew >= SEW_LAST) || (inst_vlmul == 3'b100) ||
                 (is_widen && ((inst_vlmul == 3'b011) || !WIDEN_EN)) ||
                 misaligned || overflow;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept && !illegal && (inst_vl != 8'd0)) state_next = SPLIT;
      SPLIT: if (uop_ready && (idx_q == last_q)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_q         <= '0;
      idx_q         <= '0;
      last_q        <= '0;
      widen_q       <= 1'b0;
      vd_inc_q      <= 1'b0;
      vs1_inc_q     <= 1'b0;
      illegal_pulse <= 1'b0;
    end else begin
      illegal_pulse <= 1'b0;
      if (accept) begin
        enc_q         <= inst_encoding;
        idx_q         <= '0;
        last_q        <= last_cnt[2:0];
        widen_q       <= is_widen;
        vd_inc_q      <= vd_inc;
        vs1_inc_q     <= vs1_inc;
        // A zero-length instruction is silently consumed even if malformed.
        illegal_pulse <= illegal && (inst_vl != 8'd0);
      end else if ((state == SPLIT) && uop_ready) begin
        idx_q <= (idx_q == last_q) ? 3'd0 : idx_q + 3'd1;
      end
    end
  end

  // Register-field rewrite; legality checks guarantee none of these sums wrap.
  logic [4:0] step_full, step_src, vd_out, vs2_out, vs1_out;

  always_comb begin
    step_full = {2'b00, idx_q};
    step_src  = widen_q ? {3'b000, idx_q[2:1]} : step_full;
    vd_out    = vd_inc_q  ? enc_q[11:7]  + step_full : enc_q[11:7];
    vs2_out   = enc_q[24:20] + step_src;
    vs1_out   = vs1_inc_q ? enc_q[19:15] + step_src : enc_q[19:15];
  end

  assign uop_valid    = (state == SPLIT);
  assign uop_index    = idx_q;
  assign uop_last     = (state == SPLIT) && (idx_q == last_q);
  assign uop_encoding = (state == SPLIT) ?
                        {enc_q[31:25], vs2_out, vs1_out, enc_q[14:12], vd_out, enc_q[6:0]} : 32'd0;

endmodule

// File: tb/tb_rvv_uop_splitter.sv
// Directed table-driven bench for rvv_uop_splitter, plus stall and mid-split reset sequences.
module tb_rvv_uop_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] inst_encoding = '0;
  logic [2:0]  inst_vsew = '0;
  logic [2:0]  inst_vlmul = '0;
  logic [7:0]  inst_vl = '0;
  logic        uop_valid;
  logic        uop_ready = 1'b1;
  logic [31:0] uop_encoding;
  logic [2:0]  uop_index;
  logic        uop_last;
  logic        illegal_pulse;

  rvv_uop_splitter dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_encoding(inst_encoding),
    .inst_vsew(inst_vsew), .inst_vlmul(inst_vlmul), .inst_vl(inst_vl),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_encoding(uop_encoding),
    .uop_index(uop_index), .uop_last(uop_last), .illegal_pulse(illegal_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] enc;
    logic [2:0]  vsew;
    logic [2:0]  vlmul;
    logic [7:0]  vl;
    int          n;
    bit          ill;
    logic [39:0] vd_l;
    logic [39:0] vs2_l;
    logic [39:0] vs1_l;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] mk(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                     input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd,
                                     input logic [6:0] opc);
    return {f6, vm, vs2, vs1, f3, vd, opc};
  endfunction

  function automatic logic [4:0] pick(input logic [39:0] l, input int k);
    return l[39 - 5*k -: 5];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [31:0] enc, input logic [2:0] vsew,
                     input logic [2:0] vlmul, input logic [7:0] vl, input int n, input bit ill,
                     input logic [39:0] vd_l, input logic [39:0] vs2_l, input logic [39:0] vs1_l);
    vec_t v;
    v.name = name; v.enc = enc; v.vsew = vsew; v.vlmul = vlmul; v.vl = vl;
    v.n = n; v.ill = ill; v.vd_l = vd_l; v.vs2_l = vs2_l; v.vs1_l = vs1_l;
    vecs.push_back(v);
  endtask

  task automatic issue(input logic [31:0] enc, input logic [2:0] vsew, input logic [2:0] vlmul,
                       input logic [7:0] vl);
    inst_valid = 1'b1; inst_encoding = enc; inst_vsew = vsew; inst_vlmul = vlmul; inst_vl = vl;
    @(posedge clk);
    @(negedge clk);
    inst_valid = 1'b0;
  endtask

  function automatic logic [31:0] exp_enc(input vec_t v, input int k);
    return {v.enc[31:25], pick(v.vs2_l, k), pick(v.vs1_l, k), v.enc[14:12], pick(v.vd_l, k), v.enc[6:0]};
  endfunction

  task automatic run_vec(input vec_t v);
    chk({v.name, " ready_before"}, {31'd0, inst_ready}, 32'd1);
    issue(v.enc, v.vsew, v.vlmul, v.vl);
    if (v.ill) begin
      chk({v.name, " illegal_pulse"}, {31'd0, illegal_pulse}, 32'd1);
      chk({v.name, " no_uop"}, {31'd0, uop_valid}, 32'd0);
      @(negedge clk);
      chk({v.name, " pulse_one_cycle"}, {31'd0, illegal_pulse}, 32'd0);
    end else begin
      chk({v.name, " no_illegal"}, {31'd0, illegal_pulse}, 32'd0);
      for (int k = 0; k < v.n; k++) begin
        chk({v.name, " valid"}, {31'd0, uop_valid}, 32'd1);
        chk({v.name, " index"}, {29'd0, uop_index}, k);
        chk({v.name, " encoding"}, uop_encoding, exp_enc(v, k));
        chk({v.name, " last"}, {31'd0, uop_last}, (k == v.n - 1) ? 32'd1 : 32'd0);
        chk({v.name, " busy"}, {31'd0, inst_ready}, 32'd0);
        @(negedge clk);
      end
    end
    chk({v.name, " ready_after"}, {31'd0, inst_ready}, 32'd1);
    chk({v.name, " idle_no_uop"}, {31'd0, uop_valid}, 32'd0);
  endtask

  initial begin
    vec_t v;
    // Table: name, encoding, vsew, vlmul, vl, uops, illegal, vd list, vs2 list, vs1 list (idx 0 first).
    add("vadd_vv_m4", mk(6'b000000, 1'b1, 5'd16, 5'd24, 3'b000, 5'd8, 7'b1010111), 3'd2, 3'b010, 8'd32, 4, 0,
        {5'd8, 5'd9, 5'd10, 5'd11, 20'd0}, {5'd16, 5'd17, 5'd18, 5'd19, 20'd0}, {5'd24, 5'd25, 5'd26, 5'd27, 20'd0});
`ifdef RVV_UOP_WIDEN_SPLIT_EN
    add("vwadd_vv_m2", mk(6'b110001, 1'b1, 5'd8, 5'd12, 3'b010, 5'd4, 7'b1010111), 3'd1, 3'b001, 8'd16, 4, 0,
        {5'd4, 5'd5, 5'd6, 5'd7, 20'd0}, {5'd8, 5'd8, 5'd9, 5'd9, 20'd0}, {5'd12, 5'd12, 5'd13, 5'd13, 20'd0});
`else
    add("vwadd_vv_m2", mk(6'b110001, 1'b1, 5'd8, 5'd12, 3'b010, 5'd4, 7'b1010111), 3'd1, 3'b001, 8'd16, 0, 1,
        40'd0, 40'd0, 40'd0);
`endif
    add("vadd_vx_misalign", mk(6'b000000, 1'b1, 5'd4, 5'd5, 3'b100, 5'd3, 7'b1010111), 3'd2, 3'b001, 8'd8, 0, 1,
        40'd0, 40'd0, 40'd0);
    add("vadd_vi_vl0", mk(6'b000000, 1'b1, 5'd8, 5'd3, 3'b011, 5'd0, 7'b1010111), 3'd0, 3'b011, 8'd0, 0, 0,
        40'd0, 40'd0, 40'd0);
    add("vredsum_m4", mk(6'b000000, 1'b0, 5'd8, 5'd5, 3'b010, 5'd2, 7'b1010111), 3'd2, 3'b010, 8'd16, 4, 0,
        {5'd2, 5'd2, 5'd2, 5'd2, 20'd0}, {5'd8, 5'd9, 5'd10, 5'd11, 20'd0}, {5'd5, 5'd5, 5'd5, 5'd5, 20'd0});
    add("vadd_vx_m2", mk(6'b000000, 1'b0, 5'd10, 5'd7, 3'b100, 5'd6, 7'b1010111), 3'd2, 3'b001, 8'd8, 2, 0,
        {5'd6, 5'd7, 30'd0}, {5'd10, 5'd11, 30'd0}, {5'd7, 5'd7, 30'd0});
    add("bad_opcode", mk(6'b000000, 1'b1, 5'd8, 5'd8, 3'b000, 5'd8, 7'b0000111), 3'd0, 3'b000, 8'd4, 0, 1,
        40'd0, 40'd0, 40'd0);
    add("opcfg", mk(6'b000000, 1'b1, 5'd8, 5'd8, 3'b111, 5'd8, 7'b1010111), 3'd0, 3'b000, 8'd4, 0, 1,
        40'd0, 40'd0, 40'd0);
    add("bad_sew", mk(6'b000000, 1'b1, 5'd8, 5'd8, 3'b000, 5'd8, 7'b1010111), 3'd7, 3'b000, 8'd4, 0, 1,
        40'd0, 40'd0, 40'd0);
    add("bad_lmul", mk(6'b000000, 1'b1, 5'd8, 5'd8, 3'b000, 5'd8, 7'b1010111), 3'd0, 3'b100, 8'd4, 0, 1,
        40'd0, 40'd0, 40'd0);
    add("frac_lmul", mk(6'b000000, 1'b1, 5'd30, 5'd29, 3'b000, 5'd31, 7'b1010111), 3'd0, 3'b111, 8'd2, 1, 0,
        {5'd31, 35'd0}, {5'd30, 35'd0}, {5'd29, 35'd0});
    add("vs1_overflow", mk(6'b000000, 1'b1, 5'd4, 5'd31, 3'b000, 5'd30, 7'b1010111), 3'd0, 3'b001, 8'd4, 0, 1,
        40'd0, 40'd0, 40'd0);
    add("vwadd_m8", mk(6'b110001, 1'b1, 5'd8, 5'd16, 3'b010, 5'd0, 7'b1010111), 3'd0, 3'b011, 8'd8, 0, 1,
        40'd0, 40'd0, 40'd0);
    add("vadd_vv_m8", mk(6'b000000, 1'b1, 5'd16, 5'd8, 3'b000, 5'd24, 7'b1010111), 3'd0, 3'b011, 8'd64, 8, 0,
        {5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31},
        {5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23},
        {5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15});

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst uop_valid", {31'd0, uop_valid}, 32'd0);
    chk("rst uop_last", {31'd0, uop_last}, 32'd0);
    chk("rst uop_index", {29'd0, uop_index}, 32'd0);
    chk("rst illegal", {31'd0, illegal_pulse}, 32'd0);
    chk("rst encoding", uop_encoding, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst inst_ready", {31'd0, inst_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Backpressure on idx 1 of an LMUL2 vadd.vv.
    v.name = "stall"; v.enc = mk(6'b000000, 1'b1, 5'd4, 5'd6, 3'b000, 5'd2, 7'b1010111);
    v.vd_l = {5'd2, 5'd3, 30'd0}; v.vs2_l = {5'd4, 5'd5, 30'd0}; v.vs1_l = {5'd6, 5'd7, 30'd0};
    issue(v.enc, 3'd2, 3'b001, 8'd8);
    chk("stall idx0 enc", uop_encoding, exp_enc(v, 0));
    @(negedge clk);
    uop_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("stall held valid", {31'd0, uop_valid}, 32'd1);
      chk("stall held index", {29'd0, uop_index}, 32'd1);
      chk("stall held enc", uop_encoding, exp_enc(v, 1));
      chk("stall held last", {31'd0, uop_last}, 32'd1);
      @(negedge clk);
    end
    uop_ready = 1'b1;
    chk("stall release enc", uop_encoding, exp_enc(v, 1));
    @(negedge clk);
    chk("stall done ready", {31'd0, inst_ready}, 32'd1);
    chk("stall done valid", {31'd0, uop_valid}, 32'd0);

    // Reset during idx 2 of an 8-uop instruction.
    issue(vecs[vecs.size()-1].enc, 3'd0, 3'b011, 8'd64);
    repeat (2) @(negedge clk);
    chk("midrst idx2", {29'd0, uop_index}, 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst valid", {31'd0, uop_valid}, 32'd0);
    chk("midrst index", {29'd0, uop_index}, 32'd0);
    chk("midrst enc", uop_encoding, 32'd0);
    chk("midrst last", {31'd0, uop_last}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("after_rst no_uop", {31'd0, uop_valid}, 32'd0);
      chk("after_rst ready", {31'd0, inst_ready}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
